fpu_op_issuer: RTL
==================

Name: fpu_op_issuer

Overview:
Initiator-side controller for the FPU operation interface. It accepts one floating-point operation from the integer pipeline through a valid/ready handshake, and issues it to the FPU datapath with a single-cycle request pulse. It then waits for the FPU's done strobe, or for a timeout, and returns the result with its destination register to writeback. It also short-circuits NaN operands without using the FPU and keeps completion and timeout statistics.

Parameters:
TIMEOUT, 64, WAIT-state cycles allowed for fpu_done before a forced error response (≥2).
TAG_W, 5, width of the destination register tag.
CNT_W, 16, width of the completed-operation counter.

Ports:
Clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  upstream holds a valid operation.
in_ready  out  1  block can accept an operation.
in_op  in  2  0=ADD, 1=SUB, 2=MULT, 3=DIV.
in_rs1  in  32  IEEE-754 single operand A.
in_rs2  in  32  IEEE-754 single operand B.
in_rd  in  TAG_W  destination tag.
fpu_req  out  1  one-cycle issue pulse.
fpu_sel  out  2  operation code to the FPU.
fpu_rs1  out  32  operand A to the FPU.
fpu_rs2  out  32  operand B to the FPU.
fpu_done  in  1  FPU result valid strobe.
fpu_result  in  32  FPU result.
wb_valid  out  1  response valid.
wb_ready  in  1  writeback accepts the response.
wb_rd  out  TAG_W  destination tag of the response.
wb_data  out  32  result value.
wb_err  out  1  response was forced by timeout.
op_count  out  CNT_W  completed writebacks (wraps).
timeout_count  out  8  timeouts taken (saturates at 255).

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (rst=0, asynchronous):
  - state=IDLE; all internal registers 0.
  - fpu_req=0, fpu_sel/fpu_rs1/fpu_rs2=0.
  - wb_valid=0, wb_rd=0, wb_data=0, wb_err=0.
  - op_count=0, timeout_count=0.
  - in_ready=1 (in_ready is decoded from state==IDLE).
- Reset mid-operation aborts the operation silently; no response is produced.
- IDLE:
  - On in_valid&&in_ready, latch op, rs1, rs2 and rd.
  - NaN operand (exp==8'hFF and mantissa!=0 in either operand): next state RESP with wb_data=32'h7FC00000, wb_err=0, and no fpu_req.
  - Otherwise next state ISSUE.
- ISSUE: fpu_req=1 for exactly this cycle; the wait counter clears to 0; next state WAIT.
- fpu_sel/fpu_rs1/fpu_rs2 equal the latched values from ISSUE through the end of WAIT and are otherwise held unchanged.
- WAIT:
  - fpu_done=1: capture fpu_result into wb_data, wb_err=0, next state RESP.
  - Else, counter==TIMEOUT-1: wb_data=32'h7FC00000, wb_err=1, timeout_count+1 (saturating), next state RESP.
  - Else counter+1.
  - fpu_done and timeout in the same cycle: done wins and timeout_count is unchanged.
- RESP:
  - wb_valid=1; wb_rd/wb_data/wb_err held stable until wb_ready.
  - On wb_valid&&wb_ready: op_count+1 (wraps at 2^CNT_W), next state IDLE.
  - There is no same-cycle re-accept; in_ready rises the cycle after the handshake.
- fpu_done outside WAIT (including a late done after a timeout) is ignored.
- Latency:
  - Accept edge at cycle T, fpu_req in T+1, earliest fpu_done in T+2, wb_valid in T+3.
  - NaN bypass: wb_valid in T+1.
- Throughput: at most one operation in flight.

Test Plan:
- ADD: rs1=32'h3F800000, rs2=32'h40000000, rd=5; FPU returns 32'h40400000 two cycles after fpu_req. Required: one fpu_req pulse with fpu_sel=0; wb_valid with wb_rd=5, wb_data=32'h40400000, wb_err=0; op_count=1.
- NaN bypass: rs1=32'h7FC00001, op=DIV. Required: fpu_req never asserts; wb_valid the cycle after accept with wb_data=32'h7FC00000 and wb_err=0.
- Timeout: TIMEOUT=64, no fpu_done. Required: wb_valid 64 cycles after the WAIT entry with wb_err=1 and wb_data=32'h7FC00000; timeout_count=1. A fpu_done arriving later is ignored.
- Done on timeout edge: fpu_done=1 exactly at counter==63. Required: wb_err=0, wb_data=fpu_result, timeout_count unchanged.
- Backpressure: wb_ready held 0 for 10 cycles. Required: wb_* stable; in_ready=0; a second in_valid is not accepted until the cycle after wb_ready=1.
- Reset in WAIT: assert rst=0 mid-WAIT. Required: immediately state=IDLE, fpu_req=0, wb_valid=0, counters=0, in_ready=1; no response emitted.

Source files
------------

// File: rtl/fpu_op_issuer.sv
// fpu_op_issuer
// Takes one floating-point operation from the integer pipeline, issues it to
// the FPU with a one-cycle request pulse, then waits for the FPU done strobe
// or a timeout. The result and its destination tag go to writeback. A NaN
// operand skips the FPU and returns the canonical quiet NaN. The block also
// counts completed writebacks and timeouts.
//
// Ports
//   Clk, rst             clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    operation handshake from the integer pipeline
//   in_op/in_rs1/in_rs2  operation code (0 ADD,1 SUB,2 MULT,3 DIV) and operands
//   in_rd                destination register tag
//   fpu_req              one-cycle issue pulse to the FPU
//   fpu_sel/rs1/rs2      operation and operands presented to the FPU
//   fpu_done/result      FPU result strobe and value
//   wb_valid/wb_ready    response handshake to writeback
//   wb_rd/wb_data/wb_err response tag, value, and timeout flag
//   op_count             completed writebacks (wraps)
//   timeout_count        timeouts taken (saturates at 255)
//   dbg_state            current FSM state (0 IDLE,1 ISSUE,2 WAIT,3 RESP)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. Valid is held with stable payload until that edge.
// Ready may depend on state only, never on the same-cycle valid.
module fpu_op_issuer #(
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_rd,
  output logic             fpu_req,
  output logic [1:0]       fpu_sel,
  output logic [31:0]      fpu_rs1,
  output logic [31:0]      fpu_rs2,
  input  logic             fpu_done,
  input  logic [31:0]      fpu_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_rd,
  output logic [31:0]      wb_data,
  output logic             wb_err,
  output logic [CNT_W-1:0] op_count,
  output logic [7:0]       timeout_count,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic accept, nan_in, timeout_hit;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  assign in_ready    = (state == S_IDLE);
  assign fpu_req     = (state == S_ISSUE);
  assign wb_valid    = (state == S_RESP);
  assign dbg_state   = state;
  assign accept      = in_valid && in_ready;
  assign nan_in      = is_nan(in_rs1) || is_nan(in_rs2);
  // Done has priority over the timeout in the same cycle.
  assign timeout_hit = (state == S_WAIT) && !fpu_done && (cnt == LAST);

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = nan_in ? S_RESP : S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (fpu_done || timeout_hit) state_next = S_RESP;
      S_RESP:  if (wb_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      fpu_sel       <= 2'd0;
      fpu_rs1       <= 32'd0;
      fpu_rs2       <= 32'd0;
      wb_rd         <= '0;
      wb_data       <= 32'd0;
      wb_err        <= 1'b0;
      op_count      <= '0;
      timeout_count <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            wb_rd <= in_rd;
            if (nan_in) begin
              wb_data <= QNAN;
              wb_err  <= 1'b0;
            end else begin
              // FPU-facing operands only change when an operation is issued;
              // a NaN bypass leaves them as they were.
              fpu_sel <= in_op;
              fpu_rs1 <= in_rs1;
              fpu_rs2 <= in_rs2;
            end
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          if (fpu_done) begin
            wb_data <= fpu_result;
            wb_err  <= 1'b0;
          end else if (timeout_hit) begin
            wb_data <= QNAN;
            wb_err  <= 1'b1;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: if (wb_ready) op_count <= op_count + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
